fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one byte-wide synchronous FIFO write port among NUM_REQ producers.
- Producers use a valid/ready handshake. The arbiter drives the FIFO wr/data_in pins and observes the FIFO full flag.
- Supports locked bursts of up to MAX_BURST beats, so a packet from one producer is written contiguously.
- Sits directly in front of the FIFO on the producer side.

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers. Multi-beat packets lock the grant for up to
// MAX_BURST beats so a packet lands in the FIFO contiguously.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_data,
  input  logic                        fifo_full,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [3:0]     beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [IDW-1:0] cand;
  logic           cand_vld;
  logic           beat;
  logic           burst_end;

  // Successor index with wrap from NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] id);
    if (id == IDW'(NUM_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  // State register: all registers are control, so all take the reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Candidate search: locked owner only, else first valid from rr_ptr upward.
  always_comb begin
    logic           found;
    int             j;
    logic [IDW-1:0] idx;
    cand     = '0;
    cand_vld = 1'b0;
    found    = 1'b0;
    j        = 0;
    idx      = '0;
    if (state_q == LOCKED) begin
      cand     = lock_id_q;
      cand_vld = req_valid[lock_id_q];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        idx = IDW'(j);
        if (!found && req_valid[idx]) begin
          found    = 1'b1;
          cand     = idx;
          cand_vld = 1'b1;
        end
      end
    end
  end

  // A beat needs a valid candidate and FIFO space; nothing moves under reset.
  always_comb begin
    beat      = cand_vld && !fifo_full && !rst;
    burst_end = ({1'b0, beat_cnt_q} + 5'd1) == 5'(MAX_BURST);
  end

  // Next-state logic: lock on the first beat of a multi-beat packet,
  // release on the last beat or when the burst limit is reached.
  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (beat) begin
      case (state_q)
        IDLE: begin
          if (!req_last[cand] && (MAX_BURST > 1)) begin
            state_d    = LOCKED;
            lock_id_d  = cand;
            beat_cnt_d = 4'd1;
          end else begin
            rr_ptr_d = next_idx(cand);
          end
        end
        LOCKED: begin
          if (req_last[cand] || burst_end) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = next_idx(lock_id_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: same-cycle handshake and FIFO write, all forced low in reset.
  always_comb begin
    req_ready = '0;
    fifo_wr   = beat;
    fifo_data = '0;
    if (beat) begin
      req_ready[cand] = 1'b1;
      fifo_data       = req_data[int'(cand)*DATA_W +: DATA_W];
    end
    busy     = (state_q == LOCKED) && !rst;
    grant_id = rst ? '0 : cand;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 31-entry FIFO occupancy model.
module tb_fifo_wr_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic        fifo_clr = 1'b1;
  logic        fifo_rd = 1'b0;
  int          occ = 0;
  logic [7:0]  wlog[$];

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_full(fifo_full), .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clock = ~clock;

  assign fifo_full = (occ >= 31);

  // FIFO model: occupancy and a log of every byte written.
  always @(posedge clock) begin
    if (fifo_clr) begin
      occ <= 0;
      wlog.delete();
    end else begin
      occ <= occ + (fifo_wr ? 1 : 0) - (fifo_rd ? 1 : 0);
      if (fifo_wr) wlog.push_back(fifo_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_clr = 1'b1; fifo_rd = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    tick(); tick();
    rst = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_clr = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h33221100;
    tick(); #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", fifo_wr); end
    checks++; if (fifo_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", fifo_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    do_reset();
  endtask

  task automatic test_burst_single();
    do_reset();
    req_valid = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      req_data[7:0] = 8'hA0 + 8'(b);
      req_last[0]   = (b == 3);
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL burst_ready b=%0d got=%b exp=0001", b, req_ready); end
      checks++; if (fifo_wr !== 1'b1 || fifo_data !== 8'hA0 + 8'(b)) begin failures++; $display("FAIL burst_data b=%0d got=%b/%h exp=1/%h", b, fifo_wr, fifo_data, 8'hA0 + 8'(b)); end
      checks++; if (busy !== (b > 0)) begin failures++; $display("FAIL burst_busy b=%0d got=%b exp=%b", b, busy, (b > 0)); end
      tick();
    end
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_release got=%b exp=0", busy); end
    checks++; if (wlog.size() != 4 || wlog[0] !== 8'hA0 || wlog[3] !== 8'hA3) begin failures++; $display("FAIL burst_log size=%0d exp=4 A0..A3", wlog.size()); end
    req_valid = 4'b1111; req_last = 4'b1111;
    #1;
    checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin failures++; $display("FAIL burst_rrptr got=%0d/%b exp=1/0010", grant_id, req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h13121110;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (grant_id !== 2'(c % 4) || req_ready !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_grant c=%0d got=%0d/%b exp=%0d", c, grant_id, req_ready, c % 4); end
      checks++; if (fifo_wr !== 1'b1 || fifo_data !== 8'h10 + 8'(c % 4) || busy !== 1'b0) begin failures++; $display("FAIL rr_data c=%0d got=%b/%h/%b exp=1/%h/0", c, fifo_wr, fifo_data, busy, 8'h10 + 8'(c % 4)); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_max_burst();
    int exp_g[13] = '{2,2,2,2,3,2,2,2,2,3,2,2,3};
    int exp_b[13] = '{0,1,1,1,0,0,1,1,1,0,0,1,0};
    int p;
    do_reset();
    p = 0;
    for (int c = 0; c < 13; c++) begin
      req_valid = {1'b1, (p < 10), 2'b00};
      req_last  = {1'b1, (p == 9), 2'b00};
      req_data  = {8'h30, 8'h20 + 8'(p), 16'h0};
      #1;
      checks++; if (grant_id !== 2'(exp_g[c]) || req_ready !== 4'(1 << exp_g[c]) || fifo_wr !== 1'b1) begin failures++; $display("FAIL mb_grant c=%0d got=%0d/%b exp=%0d", c, grant_id, req_ready, exp_g[c]); end
      checks++; if (busy !== exp_b[c][0]) begin failures++; $display("FAIL mb_busy c=%0d got=%b exp=%0d", c, busy, exp_b[c]); end
      checks++; if (fifo_data !== ((exp_g[c] == 2) ? 8'h20 + 8'(p) : 8'h30)) begin failures++; $display("FAIL mb_data c=%0d got=%h", c, fifo_data); end
      tick();
      if (exp_g[c] == 2) p++;
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_full();
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0010;
    for (int k = 0; k < 31; k++) begin
      req_data[15:8] = 8'(k);
      #1;
      checks++; if (fifo_wr !== 1'b1 || fifo_data !== 8'(k)) begin failures++; $display("FAIL fill_wr k=%0d got=%b/%h exp=1/%h", k, fifo_wr, fifo_data, 8'(k)); end
      tick();
    end
    req_data[15:8] = 8'h1F;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (fifo_wr !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL full_stall s=%0d got=%b/%b exp=0/0000", s, fifo_wr, req_ready); end
      tick();
    end
    fifo_rd = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL full_rdcyc got=%b exp=0", fifo_wr); end
    tick();
    fifo_rd = 1'b0;
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 8'h1F || req_ready !== 4'b0010) begin failures++; $display("FAIL full_resume got=%b/%h/%b exp=1/1f/0010", fifo_wr, fifo_data, req_ready); end
    tick();
    #1;
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL full_again got=%b exp=0", fifo_wr); end
    checks++; if (wlog.size() != 32 || wlog[30] !== 8'h1E || wlog[31] !== 8'h1F) begin failures++; $display("FAIL full_log size=%0d exp=32 ending 1e,1f", wlog.size()); end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b0011; req_last = 4'b0010; req_data = {16'h0, 8'h51, 8'h40};
    #1;
    checks++; if (req_ready !== 4'b0001 || fifo_data !== 8'h40 || busy !== 1'b0) begin failures++; $display("FAIL stall_b1 got=%b/%h/%b exp=0001/40/0", req_ready, fifo_data, busy); end
    tick();
    req_data[7:0] = 8'h41;
    #1;
    checks++; if (req_ready !== 4'b0001 || fifo_data !== 8'h41 || busy !== 1'b1) begin failures++; $display("FAIL stall_b2 got=%b/%h/%b exp=0001/41/1", req_ready, fifo_data, busy); end
    tick();
    req_valid = 4'b0010;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (fifo_wr !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL stall_hold s=%0d got=%b/%b/%b/%0d exp=0/0000/1/0", s, fifo_wr, req_ready, busy, grant_id); end
      tick();
    end
    req_valid = 4'b0011; req_data[7:0] = 8'h42;
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 8'h42 || req_ready !== 4'b0001) begin failures++; $display("FAIL stall_b3 got=%b/%h/%b exp=1/42/0001", fifo_wr, fifo_data, req_ready); end
    tick();
    req_data[7:0] = 8'h43; req_last[0] = 1'b1;
    #1;
    checks++; if (fifo_data !== 8'h43 || req_ready !== 4'b0001) begin failures++; $display("FAIL stall_b4 got=%h/%b exp=43/0001", fifo_data, req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0010 || fifo_data !== 8'h51 || busy !== 1'b0) begin failures++; $display("FAIL stall_next got=%b/%h/%b exp=0010/51/0", req_ready, fifo_data, busy); end
    checks++; if (wlog.size() != 4 || wlog[2] !== 8'h42 || wlog[3] !== 8'h43) begin failures++; $display("FAIL stall_log size=%0d exp=4 ending 42,43", wlog.size()); end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1000; req_last = 4'b0000; req_data = 32'h70000000;
    tick(); tick();
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd3) begin failures++; $display("FAIL rmid_locked got=%b/%0d exp=1/3", busy, grant_id); end
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0 || fifo_wr !== 1'b0) begin failures++; $display("FAIL rmid_inrst got=%b/%b/%b exp=0/0000/0", busy, req_ready, fifo_wr); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_after got=%b/%0d/%b exp=0/0/0001", busy, grant_id, req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_burst_single();
    test_round_robin();
    test_max_burst();
    test_full();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
